// File: rtl/hello_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
// hello_frame_decoder_pkg: symbol, segment, class and state encodings plus
// the frame classifier shared by the HELLO frame decoder.
// Revision: 1.0
// ============================================================================
package hello_frame_decoder_pkg;

  localparam logic [2:0] SYM_H     = 3'd0;
  localparam logic [2:0] SYM_E     = 3'd1;
  localparam logic [2:0] SYM_L     = 3'd2;
  localparam logic [2:0] SYM_O     = 3'd3;
  localparam logic [2:0] SYM_BLANK = 3'd4;
  localparam logic [2:0] SYM_BAD   = 3'd7;

  localparam logic [6:0] SEG_H   = 7'b0001001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_O   = 7'b1000000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [2:0] CLS_BLANK = 3'd5;
  localparam logic [2:0] CLS_BAD   = 3'd7;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_LOCK = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  function automatic logic [2:0] word_sym(input int idx);
    case (idx)
      0:       return SYM_H;
      1:       return SYM_E;
      2, 3:    return SYM_L;
      default: return SYM_O;
    endcase
  endfunction

  // syms[14:12] is the leftmost digit; rotation r starts the word at letter r.
  function automatic logic [2:0] frame_class(input logic [14:0] syms);
    logic [2:0] cls;
    logic       hit;
    cls = CLS_BAD;
    if (syms == {5{SYM_BLANK}}) cls = CLS_BLANK;
    for (int r = 0; r < 5; r++) begin
      hit = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (syms[(4-i)*3 +: 3] != word_sym((i + r) % 5)) hit = 1'b0;
      end
      if (hit) cls = 3'(r);
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hello_frame_decoder_char.sv
`default_nettype none
// ============================================================================
// seg7_char_decoder: maps one active-low 7-segment code to a symbol code.
// Revision: 1.0
// ============================================================================
module seg7_char_decoder
  import hello_frame_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [2:0] sym_o
);

  always_comb begin
    case (seg_i)
      SEG_H:   sym_o = SYM_H;
      SEG_E:   sym_o = SYM_E;
      SEG_L:   sym_o = SYM_L;
      SEG_O:   sym_o = SYM_O;
      SEG_OFF: sym_o = SYM_BLANK;
      default: sym_o = SYM_BAD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hello_frame_decoder.sv
`default_nettype none
// ============================================================================
// hello_frame_decoder: recovers the HELLO rotation shown on HEX4..HEX0,
// debounces frame changes, flags illegal frames and counts forward steps.
// Revision: 1.0
// ============================================================================
module hello_frame_decoder
  import hello_frame_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [6:0]       HEX4,
  input  logic [6:0]       HEX3,
  input  logic [6:0]       HEX2,
  input  logic [6:0]       HEX1,
  input  logic [6:0]       HEX0,
  output logic [2:0]       ROT,
  output logic             ROT_VALID,
  output logic             ERR,
  output logic             CHANGE,
  output logic             STEP_FWD,
  output logic [CNT_W-1:0] STEP_CNT
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

  logic [34:0]      hex_q;
  logic [14:0]      syms;
  logic [2:0]       cls;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, legal;
  logic [1:0]       state_q, state_d;
  logic [2:0]       rot_q, rot_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             change_q, change_d, step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rot_next;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_dec
      seg7_char_decoder u_dec (
        .seg_i (hex_q[i*7 +: 7]),
        .sym_o (syms[i*3 +: 3])
      );
    end
  endgenerate

  assign cls   = frame_class(syms);
  assign legal = (cls != CLS_BAD);

  // Accept fires once, on the edge where the count first reaches the limit.
  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    if (cls != cand_q) begin
      cand_d  = cls;
      count_d = CNT_W'(1);
    end else if (count_q != STABLE_LIM) begin
      count_d = count_q + 1'b1;
    end
  end

  assign accept = (count_d == STABLE_LIM) && ((cls != cand_q) || (count_q != STABLE_LIM));

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      hex_q   <= {5{SEG_OFF}};
      cand_q  <= CLS_BAD;
      count_q <= '0;
    end else begin
      hex_q   <= {HEX4, HEX3, HEX2, HEX1, HEX0};
      cand_q  <= cand_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_WAIT;
      rot_q    <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      change_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rot_q    <= rot_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      change_q <= change_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_WAIT:  state_d = legal ? S_LOCK : S_ERR;
        S_LOCK:  state_d = legal ? S_LOCK : S_ERR;
        S_ERR:   state_d = legal ? S_LOCK : S_ERR;
        default: state_d = S_WAIT;
      endcase
    end
  end

  assign rot_next = (rot_q == 3'd4) ? 3'd0 : rot_q + 3'd1;

  always_comb begin
    rot_d    = rot_q;
    valid_d  = valid_q;
    err_d    = err_q;
    change_d = 1'b0;
    step_d   = 1'b0;
    cnt_d    = cnt_q;
    if (accept) begin
      if (!legal) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
      end else if (state_q != S_LOCK || cls != rot_q) begin
        rot_d    = cls;
        valid_d  = 1'b1;
        change_d = 1'b1;
        // Forward steps only count between two rotations while locked.
        if (state_q == S_LOCK && rot_q < CLS_BLANK && cls < CLS_BLANK && cls == rot_next) begin
          step_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
    end
  end

  assign ROT       = rot_q;
  assign ROT_VALID = valid_q;
  assign ERR       = err_q;
  assign CHANGE    = change_q;
  assign STEP_FWD  = step_q;
  assign STEP_CNT  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hello_frame_decoder.sv
`default_nettype none
// ============================================================================
// tb_hello_frame_decoder: directed self-checking bench for hello_frame_decoder.
// Revision: 1.0
// ============================================================================
module tb_hello_frame_decoder;

  localparam logic [6:0] H = 7'b0001001;
  localparam logic [6:0] E = 7'b0000110;
  localparam logic [6:0] L = 7'b1000111;
  localparam logic [6:0] O = 7'b1000000;
  localparam logic [6:0] B = 7'b1111111;

  localparam logic [34:0] F_ROT0  = {H, E, L, L, O};
  localparam logic [34:0] F_ROT1  = {E, L, L, O, H};
  localparam logic [34:0] F_ROT2  = {L, L, O, H, E};
  localparam logic [34:0] F_ROT3  = {L, O, H, E, L};
  localparam logic [34:0] F_ROT4  = {O, H, E, L, L};
  localparam logic [34:0] F_BLANK = {B, B, B, B, B};
  localparam logic [34:0] F_BAD   = {H, E, L, L, 7'b0100100};

  logic       CLOCK_50;
  logic       RST_N;
  logic [6:0] HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [2:0] ROT;
  logic       ROT_VALID, ERR, CHANGE, STEP_FWD;
  logic [7:0] STEP_CNT;

  int n_pass  = 0;
  int n_total = 0;

  hello_frame_decoder #(.STABLE_CYCLES(16), .CNT_W(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .RST_N     (RST_N),
    .HEX4      (HEX4),
    .HEX3      (HEX3),
    .HEX2      (HEX2),
    .HEX1      (HEX1),
    .HEX0      (HEX0),
    .ROT       (ROT),
    .ROT_VALID (ROT_VALID),
    .ERR       (ERR),
    .CHANGE    (CHANGE),
    .STEP_FWD  (STEP_FWD),
    .STEP_CNT  (STEP_CNT)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input int rot, input int valid, input int err,
                          input int chg, input int step, input int cnt);
    chk({tag, ".rot"},   int'(ROT),       rot);
    chk({tag, ".valid"}, int'(ROT_VALID), valid);
    chk({tag, ".err"},   int'(ERR),       err);
    chk({tag, ".chg"},   int'(CHANGE),    chg);
    chk({tag, ".step"},  int'(STEP_FWD),  step);
    chk({tag, ".cnt"},   int'(STEP_CNT),  cnt);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_frame(input logic [34:0] f);
    {HEX4, HEX3, HEX2, HEX1, HEX0} = f;
  endtask

  // Frame driven just after edge j is sampled at j+1 and accepted at j+17.
  task automatic accept_frame(input string tag, input logic [34:0] f, input int rot,
                              input int valid, input int err, input int chg,
                              input int step, input int cnt);
    set_frame(f);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, ".early_chg"},  int'(CHANGE),   0);
      chk({tag, ".early_step"}, int'(STEP_FWD), 0);
    end
    tick();
    chk_outs(tag, rot, valid, err, chg, step, cnt);
    tick();
    chk({tag, ".pulse_end_chg"},  int'(CHANGE),   0);
    chk({tag, ".pulse_end_step"}, int'(STEP_FWD), 0);
  endtask

  initial begin
    RST_N = 1'b0;
    set_frame(F_ROT0);
    tick();
    tick();
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;

    accept_frame("hello", F_ROT0, 0, 1, 0, 1, 0, 0);
    accept_frame("r0_r1", F_ROT1, 1, 1, 0, 1, 1, 1);
    accept_frame("r1_r2", F_ROT2, 2, 1, 0, 1, 1, 2);
    accept_frame("r2_r3", F_ROT3, 3, 1, 0, 1, 1, 3);
    accept_frame("r3_r4", F_ROT4, 4, 1, 0, 1, 1, 4);
    accept_frame("r4_r0", F_ROT0, 0, 1, 0, 1, 1, 5);
    accept_frame("r0_r1b", F_ROT1, 1, 1, 0, 1, 1, 6);
    accept_frame("r1_r2b", F_ROT2, 2, 1, 0, 1, 1, 7);

    set_frame(F_ROT3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_chg", int'(CHANGE), 0);
    end
    set_frame(F_ROT2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("glitch_back_chg", int'(CHANGE), 0);
    end
    chk_outs("glitch_hold", 2, 1, 0, 0, 0, 7);

    accept_frame("r2_r3b",   F_ROT3,  3, 1, 0, 1, 1, 8);
    accept_frame("r3_r1",    F_ROT1,  1, 1, 0, 1, 0, 8);
    accept_frame("r1_blank", F_BLANK, 5, 1, 0, 1, 0, 8);
    accept_frame("blank_r1", F_ROT1,  1, 1, 0, 1, 0, 8);

    set_frame(F_BAD);
    for (int i = 0; i < 17; i++) tick();
    chk("bad.err",   int'(ERR),       1);
    chk("bad.valid", int'(ROT_VALID), 0);
    chk("bad.rot",   int'(ROT),       1);
    chk("bad.step",  int'(STEP_FWD),  0);
    chk("bad.cnt",   int'(STEP_CNT),  8);
    accept_frame("recover", F_ROT0, 0, 1, 1, 1, 0, 8);

    set_frame(F_ROT1);
    for (int i = 0; i < 8; i++) tick();
    RST_N = 1'b0;
    #1;
    chk_outs("rst_async", 0, 0, 0, 0, 0, 0);
    tick();
    chk_outs("rst_held", 0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    accept_frame("post_rst", F_ROT1, 1, 1, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
